// File: rtl/mathb_tpram_fetch.sv
// mathb_tpram_fetch: walks operand/coefficient TPRAMs for an N-tap dot product and drives MAC clear/enable/done.
// Define MATHB_FETCH_STRIDE_EN to add the oper_stride port (operand stride otherwise fixed at 1).
module mathb_tpram_fetch #(
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 1,
  parameter int OUT_LAT = 2
) (
  input  logic              EFPGA2MATHB_CLK,
  input  logic              acc_ff_rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] tap_count,
  input  logic [ADDR_W-1:0] oper_base,
  input  logic [ADDR_W-1:0] coef_base,
`ifdef MATHB_FETCH_STRIDE_EN
  input  logic [ADDR_W-1:0] oper_stride,
`endif
  output logic [ADDR_W-1:0] OPER_R_ADDR,
  output logic              OPER_R_EN,
  output logic [ADDR_W-1:0] COEF_R_ADDR,
  output logic              COEF_R_EN,
  output logic              MATHB_CLK_EN,
  output logic              MATHB_ACC_CLEAR,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, oaddr_q, oaddr_d, caddr_q, caddr_d, stride;
  logic [RD_LAT-1:0] vld_q, vld_d, first_q, first_d;
  logic first_tap_q, first_tap_d, issue, accept, last;
`ifdef MATHB_FETCH_STRIDE_EN
  logic [ADDR_W-1:0] stride_q, stride_d;
  always_comb stride_d = accept ? oper_stride : stride_q;
  always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn)
    if (!acc_ff_rstn) stride_q <= '0;
    else stride_q <= stride_d;
  assign stride = stride_q;
`else
  assign stride = ADDR_W'(1);
`endif
  always_comb begin
    issue       = state_q == ISSUE;
    accept      = state_q == IDLE && start && !abort && tap_count != '0;
    last        = cnt_q == '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    oaddr_d     = oaddr_q;
    caddr_d     = caddr_q;
    first_tap_d = first_tap_q;
    vld_d       = abort ? '0 : (vld_q << 1) | RD_LAT'(issue);
    first_d     = abort ? '0 : (first_q << 1) | RD_LAT'(issue && first_tap_q);
    if (abort) state_d = IDLE;
    else if (accept) begin
      state_d     = ISSUE;
      cnt_d       = tap_count - 1'b1;
      oaddr_d     = oper_base;
      caddr_d     = coef_base;
      first_tap_d = 1'b1;
    end else if (issue) begin
      first_tap_d = 1'b0;
      if (last) begin
        state_d = DRAIN;
        cnt_d   = ADDR_W'(RD_LAT + OUT_LAT - 1);
      end else begin
        cnt_d   = cnt_q - 1'b1;
        oaddr_d = oaddr_q + stride;
        caddr_d = caddr_q + 1'b1;
      end
    end else if (state_q == DRAIN) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = last ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn)
    if (!acc_ff_rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      oaddr_q     <= '0;
      caddr_q     <= '0;
      vld_q       <= '0;
      first_q     <= '0;
      first_tap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      oaddr_q     <= oaddr_d;
      caddr_q     <= caddr_d;
      vld_q       <= vld_d;
      first_q     <= first_d;
      first_tap_q <= first_tap_d;
    end
  assign OPER_R_ADDR     = oaddr_q;
  assign COEF_R_ADDR     = caddr_q;
  assign OPER_R_EN       = issue;
  assign COEF_R_EN       = issue;
  assign MATHB_CLK_EN    = vld_q[RD_LAT-1];
  assign MATHB_ACC_CLEAR = vld_q[RD_LAT-1] & first_q[RD_LAT-1];
  assign busy            = state_q != IDLE;
  assign done            = state_q == DRAIN && last;
endmodule

// File: tb/tb_mathb_tpram_fetch.sv
// tb_mathb_tpram_fetch: random and directed jobs against TPRAM/MAC models and a per-cycle timing reference.
module tb_mathb_tpram_fetch;
  localparam int AW = 10;
  logic clk = 0, rstn = 0, start = 0, abort = 0;
  logic [AW-1:0] tap_count = 0, oper_base = 0, coef_base = 0;
`ifdef MATHB_FETCH_STRIDE_EN
  logic [AW-1:0] oper_stride = 1;
`endif
  logic [AW-1:0] OPER_R_ADDR, COEF_R_ADDR;
  logic OPER_R_EN, COEF_R_EN, MATHB_CLK_EN, MATHB_ACC_CLEAR, busy, done;
  logic [15:0] oper_mem [1024];
  logic [15:0] coef_mem [1024];
  logic [15:0] od, cd;
  logic [31:0] acc, mac_out;
  int total = 0, bad = 0;

  mathb_tpram_fetch dut (
    .EFPGA2MATHB_CLK(clk), .acc_ff_rstn(rstn), .start(start), .abort(abort),
    .tap_count(tap_count), .oper_base(oper_base), .coef_base(coef_base),
`ifdef MATHB_FETCH_STRIDE_EN
    .oper_stride(oper_stride),
`endif
    .OPER_R_ADDR(OPER_R_ADDR), .OPER_R_EN(OPER_R_EN), .COEF_R_ADDR(COEF_R_ADDR),
    .COEF_R_EN(COEF_R_EN), .MATHB_CLK_EN(MATHB_CLK_EN), .MATHB_ACC_CLEAR(MATHB_ACC_CLEAR),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // TPRAMs with one-cycle read latency, MAC accumulator, then registered MAC output
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      od <= 0; cd <= 0; acc <= 0; mac_out <= 0;
    end else begin
      if (OPER_R_EN) od <= oper_mem[OPER_R_ADDR];
      if (COEF_R_EN) cd <= coef_mem[COEF_R_ADDR];
      if (MATHB_CLK_EN) acc <= (MATHB_ACC_CLEAR ? 32'd0 : acc) + od * cd;
      mac_out <= acc;
    end

  // Starts a job in the current cycle; j counts cycles after the accepting edge
  task automatic test_job(input int n, input logic [AW-1:0] ob, input logic [AW-1:0] cb,
                          input logic [AW-1:0] s, input int restart_at);
    logic [31:0] exp_sum;
    logic [5:0] f, ef;
    logic [AW-1:0] eo, ec;
    int m;
    exp_sum = 0;
    for (int k = 0; k < n; k++) exp_sum += oper_mem[AW'(ob + k * s)] * coef_mem[AW'(cb + k)];
    tap_count = AW'(n); oper_base = ob; coef_base = cb;
`ifdef MATHB_FETCH_STRIDE_EN
    oper_stride = s;
`endif
    start = 1;
    @(negedge clk);
    start = 0; tap_count = AW'($urandom); oper_base = AW'($urandom); coef_base = AW'($urandom);
`ifdef MATHB_FETCH_STRIDE_EN
    oper_stride = AW'($urandom);
`endif
    for (int j = 1; j <= n + 4; j++) begin
      m  = j < n ? j : n;
      ef = {j <= n, j <= n, j >= 2 && j <= n + 1, j == 2, j <= n + 3, j == n + 3};
      f  = {OPER_R_EN, COEF_R_EN, MATHB_CLK_EN, MATHB_ACC_CLEAR, busy, done};
      eo = AW'(ob + (m - 1) * s);
      ec = AW'(cb + m - 1);
      total++;
      if (f !== ef) begin
        bad++; $display("FAIL flags n=%0d j=%0d {ren,ren,clken,clr,busy,done} got=%b want=%b", n, j, f, ef);
      end
      total++;
      if ({OPER_R_ADDR, COEF_R_ADDR} !== {eo, ec}) begin
        bad++; $display("FAIL addr n=%0d j=%0d got oper=%h coef=%h want oper=%h coef=%h", n, j, OPER_R_ADDR, COEF_R_ADDR, eo, ec);
      end
      if (j == n + 3) begin
        total++;
        if (mac_out !== exp_sum) begin
          bad++; $display("FAIL sum n=%0d got=%h want=%h", n, mac_out, exp_sum);
        end
      end
      if (j == restart_at) begin
        start = 1; tap_count = 5;
      end else start = 0;
      if (j < n + 4) @(negedge clk);
    end
    start = 0;
  endtask

  task automatic test_reset;
    rstn = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({OPER_R_EN, COEF_R_EN, MATHB_CLK_EN, MATHB_ACC_CLEAR, busy, done, OPER_R_ADDR, COEF_R_ADDR} !== '0) begin
      bad++; $display("FAIL reset outputs not zero");
    end
    rstn = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    test_job(4, 10'h010, 10'h200, 1, 0);
  endtask

  task automatic test_wrap;
    test_job(3, 10'h3FE, 10'h3FF, 1, 0);
  endtask

  task automatic test_zero;
    tap_count = 0; start = 1;
    @(negedge clk);
    start = 0;
    for (int j = 0; j < 5; j++) begin
      total++;
      if ({OPER_R_EN, COEF_R_EN, MATHB_CLK_EN, busy, done} !== 5'b0) begin
        bad++; $display("FAIL zero_taps j=%0d got=%b want=00000", j, {OPER_R_EN, COEF_R_EN, MATHB_CLK_EN, busy, done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort;
    tap_count = 8; oper_base = AW'($urandom); coef_base = AW'($urandom); start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    total++;
    if ({OPER_R_EN, COEF_R_EN, MATHB_CLK_EN, MATHB_ACC_CLEAR, busy, done} !== 6'b0) begin
      bad++; $display("FAIL abort flags got=%b want=000000", {OPER_R_EN, COEF_R_EN, MATHB_CLK_EN, MATHB_ACC_CLEAR, busy, done});
    end
    test_job(3, AW'($urandom), AW'($urandom), 1, 0);
  endtask

  task automatic test_busy_start;
    test_job(6, AW'($urandom), AW'($urandom), 1, 3);
    test_job(2, AW'($urandom), AW'($urandom), 1, 4);
  endtask

  task automatic test_back_to_back;
    test_job(5, AW'($urandom), AW'($urandom), 1, 0);
    test_job(1, AW'($urandom), AW'($urandom), 1, 0);
    test_job(2, AW'($urandom), AW'($urandom), 1, 0);
  endtask

`ifdef MATHB_FETCH_STRIDE_EN
  task automatic test_stride;
    test_job(3, 0, AW'($urandom), 4, 0);
    test_job(4, AW'($urandom), AW'($urandom), 0, 0);
  endtask
`endif

  task automatic test_random;
    logic [AW-1:0] s;
    for (int i = 0; i < 20; i++) begin
      s = 1;
`ifdef MATHB_FETCH_STRIDE_EN
      s = AW'($urandom);
`endif
      test_job($urandom_range(1, 20), AW'($urandom), AW'($urandom), s, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    tap_count = 6; oper_base = AW'($urandom); coef_base = AW'($urandom); start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 rstn = 0;
    #1;
    total++;
    if ({OPER_R_EN, COEF_R_EN, MATHB_CLK_EN, MATHB_ACC_CLEAR, busy, done, OPER_R_ADDR, COEF_R_ADDR} !== '0) begin
      bad++; $display("FAIL mid_reset outputs not cleared");
    end
    @(negedge clk);
    rstn = 1;
    for (int j = 0; j < 10; j++) begin
      total++;
      if ({OPER_R_EN, MATHB_CLK_EN, busy, done} !== 4'b0) begin
        bad++; $display("FAIL post_reset j=%0d got=%b want=0000", j, {OPER_R_EN, MATHB_CLK_EN, busy, done});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      oper_mem[i] = 16'($urandom);
      coef_mem[i] = 16'($urandom);
    end
    test_reset;
    test_basic;
    test_wrap;
    test_zero;
    test_abort;
    test_busy_start;
    test_back_to_back;
`ifdef MATHB_FETCH_STRIDE_EN
    test_stride;
`endif
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mathb_tpram_fetch.md
# mathb_tpram_fetch

Operand/coefficient fetch sequencer that sits directly upstream of the math block. It walks the operand and coefficient TPRAMs for an N-tap dot product and drives each TPRAM's read address and enable. It also drives the math block's accumulator clear and clock-enable, so that every tap is accumulated exactly once. It raises a one-cycle `done` when the finished sum is visible on the math block's registered output.

## Interface
Parameters:
- `ADDR_W`, 10: TPRAM address width; also the width of the tap count.
- `RD_LAT`, 1: TPRAM read latency, in cycles from address to `R_DATA`.
- `OUT_LAT`, 2: cycles from the last accumulated tap to the valid registered MAC output.

Ports:
- `EFPGA2MATHB_CLK`  in  1  block clock; all logic on the rising edge.
- `acc_ff_rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle job request.
- `abort`  in  1  synchronous job cancel.
- `tap_count`  in  ADDR_W  number of taps N; sampled on accepted `start`.
- `oper_base`  in  ADDR_W  first operand address; sampled on accepted `start`.
- `coef_base`  in  ADDR_W  first coefficient address; sampled on accepted `start`.
- `oper_stride`  in  ADDR_W  operand address increment; present only with `MATHB_FETCH_STRIDE_EN`.
- `OPER_R_ADDR`  out  ADDR_W  operand TPRAM read address.
- `OPER_R_EN`  out  1  operand TPRAM read enable.
- `COEF_R_ADDR`  out  ADDR_W  coefficient TPRAM read address.
- `COEF_R_EN`  out  1  coefficient TPRAM read enable.
- `MATHB_CLK_EN`  out  1  drives `EFPGA_MATHB_CLK_EN`; high in each cycle that tap data is valid at the math block.
- `MATHB_ACC_CLEAR`  out  1  drives `EFPGA_MATHB_MAC_ACC_CLEAR`; high only in the tap-0 data cycle.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` is high, inclusive.
- `done`  out  1  single-cycle pulse; the result is valid on `FMATHB_EFPGA_MAC_OUT` in that cycle.

## Operation
- States and transitions:
  - IDLE → ISSUE on `start` when `tap_count` != 0.
  - ISSUE → DRAIN after tap N-1 is issued.
  - DRAIN → IDLE after RD_LAT+OUT_LAT cycles; `done` is high in the last DRAIN cycle.
- `start` handling:
  - Accepted only in IDLE.
  - Ignored while `busy`.
  - Ignored when `tap_count` == 0: no state change, no `done`.
- In ISSUE, tap k (k = 0..N-1) is issued in the k-th ISSUE cycle:
  - `OPER_R_EN` = `COEF_R_EN` = 1.
  - `OPER_R_ADDR` = `oper_base` + k·stride.
  - `COEF_R_ADDR` = `coef_base` + k.
- Address arithmetic is modulo 2^ADDR_W; wrap-around past the top of the TPRAM is legal and silent.
- A RD_LAT-deep valid shift register delays each issue:
  - `MATHB_CLK_EN` = delayed valid.
  - `MATHB_ACC_CLEAR` = delayed valid AND delayed first-tap flag.
- The math block's TPRAM source selects (`OPER_defPin`/`COEF_defPin` = 2'b10) are static and outside this block.
- `abort`, in any state:
  - Next state is IDLE.
  - The valid pipeline is flushed, so `MATHB_CLK_EN`, `MATHB_ACC_CLEAR` and `R_EN` are 0 from the next cycle.
  - No `done` is produced.
  - `abort` has priority over `start` in the same cycle.
- Outputs in IDLE: `R_EN` = 0. Addresses hold their last value.

## Timing
- Reset values: all outputs are 0, state is IDLE, and the pipeline is empty.
- `start` sampled at edge E0. Tap k is issued in the cycle after edge E0+k.
- Tap k's data and `MATHB_CLK_EN` are high RD_LAT cycles after its issue cycle.
- `done` is high at cycle E0 + N + RD_LAT + OUT_LAT. With the defaults, that is N+3 cycles after `start`.
- Total job occupancy is N+RD_LAT+OUT_LAT cycles. A back-to-back `start` is accepted in the cycle immediately after `done`.
- Asserting `acc_ff_rstn` mid-job immediately clears the state and all outputs. The math block's output FF shares this reset, so no stale `done` is possible.

## Configuration
- `MATHB_FETCH_STRIDE_EN` defined:
  - The `oper_stride` port exists.
  - stride = `oper_stride`, sampled on accepted `start`.
  - Stride 0 is legal: the same operand is reused N times.
- `MATHB_FETCH_STRIDE_EN` undefined:
  - The port is absent.
  - stride is hard-wired to 1.
- Coefficient stride is always 1.

## Test plan
- Reset, then `start` with N=4, `oper_base`=0x010, `coef_base`=0x200:
  - Addresses are 0x010..0x013 and 0x200..0x203 in 4 consecutive cycles.
  - `MATHB_ACC_CLEAR` is high once, one cycle after the first issue.
  - `done` is high exactly 7 cycles after `start`; `busy` is high for those 7 cycles.
- Wrap-around: N=3, `oper_base`=0x3FE → `OPER_R_ADDR` = 0x3FE, 0x3FF, 0x000.
- `start` with `tap_count`=0 → no `R_EN`, no `done`, `busy` stays 0.
- `abort` on the 2nd ISSUE cycle of an N=8 job:
  - `R_EN` and `MATHB_CLK_EN` are 0 from the following cycle.
  - No `done`.
  - A new `start` one cycle later is accepted.
- `start` pulsed while `busy` → ignored; exactly one `done` for the original job.
- With `MATHB_FETCH_STRIDE_EN`, `oper_stride`=4, N=3, `oper_base`=0 → `OPER_R_ADDR` = 0, 4, 8; `COEF_R_ADDR` increments by 1.
- Expected sums are compared against `FMATHB_EFPGA_MAC_OUT` in the `done` cycle in 32-bit mode.
